mult_div_unit: RTL and testbench

//  Iterative MIPS multiply/divide unit with architectural HI/LO registers.

---
 rtl/mdu_pkg.sv | 29 ++
 rtl/mdu_iter_core.sv | 33 +++
 rtl/mult_div_unit.sv | 163 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: op encodings, FSM states and
// divide-by-zero constants.
package mdu_pkg;

  localparam int unsigned MduWidth = 32;

  localparam logic [1:0] MDU_MULT  = 2'd0;
  localparam logic [1:0] MDU_MULTU = 2'd1;
  localparam logic [1:0] MDU_DIV   = 2'd2;
  localparam logic [1:0] MDU_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix
  } mdu_state_e;

  // Quotient bit fill used when the divisor is zero (all ones).
  localparam logic DivZeroQuoBit = 1'b1;

  function automatic logic op_is_div(input logic [1:0] op);
    return !(op == MDU_MULT || op == MDU_MULTU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// One combinational iteration: shift-add multiply step or restoring divide step on the
// shared (2*Width+1)-bit accumulator.
module mdu_iter_core
  import mdu_pkg::*;
#(
  parameter int unsigned Width = MduWidth
) (
  input  logic               div_i,
  input  logic [2*Width:0]   acc_i,
  input  logic [Width-1:0]   opd_i,
  output logic [2*Width:0]   acc_o
);

  logic [Width:0]   sum;
  logic [Width:0]   shifted;
  logic [Width-1:0] diff;
  logic             fits;

  always_comb begin
    // Multiply: upper half accumulates the multiplicand when the current multiplier bit is set.
    sum     = acc_i[2*Width:Width] + (acc_i[0] ? {1'b0, opd_i} : '0);
    // Divide: partial remainder shifted left with the next dividend bit.
    shifted = acc_i[2*Width-1:Width-1];
    fits    = shifted >= {1'b0, opd_i};
    diff    = shifted[Width-1:0] - opd_i;
    if (div_i) begin
      acc_o = {1'b0, (fits ? diff : shifted[Width-1:0]), acc_i[Width-2:0], fits};
    end else begin
      acc_o = {1'b0, sum, acc_i[Width-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers.
// Define FAST_MULT_EN to complete MULT/MULTU in a single cycle; divides stay iterative.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MduWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam int unsigned AccW = 2 * WIDTH + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  mdu_state_e       state_q, state_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [AccW-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0] opd_q, opd_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [AccW-1:0]  iter_acc;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic             div_zero;

  always_comb begin
    a_neg    = op_is_signed(op) & a[WIDTH-1];
    b_neg    = op_is_signed(op) & b[WIDTH-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    prod_fix = neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
    quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    // With a zero divisor the remainder ends as |a|, so the fix-up restores the raw a.
    rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    div_zero = (opd_q == '0);
  end

`ifdef FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_mag;
  logic [2*WIDTH-1:0] fast_prod;
  always_comb begin
    fast_mag  = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
    fast_prod = (a_neg ^ b_neg) ? -fast_mag : fast_mag;
  end
`endif

  mdu_iter_core #(
    .Width (WIDTH)
  ) u_iter_core (
    .div_i (is_div_q),
    .acc_i (acc_q),
    .opd_i (opd_q),
    .acc_o (iter_acc)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    opd_d     = opd_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
`ifdef FAST_MULT_EN
          if (!op_is_div(op)) begin
            {hi_d, lo_d} = fast_prod;
            done_d       = 1'b1;
          end else
`endif
          begin
            state_d   = StRun;
            count_d   = '0;
            is_div_d  = op_is_div(op);
            neg_d     = a_neg ^ b_neg;
            rem_neg_d = a_neg;
            // Multiply: opd is the multiplicand, low half the multiplier.
            // Divide: opd is the divisor, low half the dividend.
            opd_d     = op_is_div(op) ? b_mag : a_mag;
            acc_d     = {{(WIDTH + 1){1'b0}}, (op_is_div(op) ? a_mag : b_mag)};
          end
        end else begin
          if (mthi) hi_d = a;
          if (mtlo) lo_d = a;
        end
      end
      StRun: begin
        acc_d   = iter_acc;
        count_d = count_q + 1'b1;
        if (count_q == CntLast) begin
          state_d = StFix;
          count_d = '0;
        end
      end
      StFix: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = div_zero ? {WIDTH{DivZeroQuoBit}} : quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      count_q   <= '0;
      acc_q     <= '0;
      opd_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      opd_q     <= opd_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: arithmetic reference model, per-cycle compare,
// directed corner cases and randomized traffic.
module tb_mult_div_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = 2'd0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          mthi = 1'b0;
  logic          mtlo = 1'b0;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  always #5 clk = ~clk;

  mult_div_unit #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {hi, lo} from plain arithmetic.
  function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] x,
                                         input logic [31:0] y);
    longint sx, sy, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: return 64'(sx * sy);
      2'd1: return {32'b0, x} * {32'b0, y};
      2'd2: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] o);
`ifdef FAST_MULT_EN
    if (!o[1]) return 0;
`endif
    return W + 1;
  endfunction

  // Reference model: countdown of remaining busy cycles plus pending result.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] m_res = '0;
  int          m_cnt = 0;
  logic        m_done = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hi   <= '0;
      m_lo   <= '0;
      m_cnt  <= 0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          {m_hi, m_lo} <= m_res;
          m_done       <= 1'b1;
        end
      end else if (start) begin
`ifdef FAST_MULT_EN
        if (!op[1]) begin
          {m_hi, m_lo} <= ref_op(op, a, b);
          m_done       <= 1'b1;
        end else
`endif
        begin
          m_res <= ref_op(op, a, b);
          m_cnt <= W + 1;
        end
      end else begin
        if (mthi) m_hi <= a;
        if (mtlo) m_lo <= a;
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      chk("cyc_busy", 64'(busy), 64'(m_cnt != 0));
      chk("cyc_done", 64'(done), 64'(m_done));
      chk("cyc_hi", 64'(hi), 64'(m_hi));
      chk("cyc_lo", 64'(lo), 64'(m_lo));
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    #2;
    while (!done && n < 40) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles at %0t", $time);
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [63:0] exp);
    int lat;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    chk({name, "_lat"}, 64'(lat), 64'(exp_lat(o)));
    chk(name, {hi, lo}, exp);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_hilo", {hi, lo}, 64'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Hand-computed values pin the reference model.
    chk("pin_mult", ref_op(2'd0, 32'hFFFF_FFFD, 32'd7), 64'hFFFF_FFFF_FFFF_FFEB);
    chk("pin_div", ref_op(2'd2, 32'hFFFF_FF9C, 32'd7), 64'hFFFF_FFFE_FFFF_FFF2);
    chk("pin_divu", ref_op(2'd3, 32'd100, 32'd7), {32'd2, 32'd14});

    run_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("divu", 2'd3, 32'd100, 32'd7, {32'd2, 32'd14});
    run_op("div_neg", 2'd2, 32'hFFFF_FF9C, 32'd7, 64'hFFFF_FFFE_FFFF_FFF2);
    run_op("div_zero", 2'd2, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF});
    run_op("div_zero_neg", 2'd2, 32'hFFFF_FFF0, 32'd0, {32'hFFFF_FFF0, 32'hFFFF_FFFF});
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("mult_min", 2'd0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);

    // Start and move during RUN are ignored.
    @(negedge clk);
    op = 2'd3; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    op = 2'd1; a = 32'd5; b = 32'd5; start = 1'b1; mthi = 1'b1;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    wait_done(lat);
    chk("hazard_lat", 64'(lat), 64'(W + 1 - 11));
    chk("hazard_res", {hi, lo}, {32'd2, 32'd14});

    // Reset at RUN cycle 5.
    @(negedge clk);
    op = 2'd2; a = 32'hFFFF_FF9C; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #2;
    chk("midrst_busy", 64'(busy), 64'h0);
    chk("midrst_hilo", {hi, lo}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mthi = 1'b1; a = 32'h1234;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b1; a = 32'h5678;
    #2;
    chk("mthi", 64'(hi), 64'h1234);
    @(negedge clk);
    mtlo = 1'b0;
    #2;
    chk("mtlo", {hi, lo}, {32'h1234, 32'h5678});
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; a = 32'hCAFE_F00D;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    #2;
    chk("mthi_mtlo", {hi, lo}, {32'hCAFE_F00D, 32'hCAFE_F00D});

    // Start wins over a simultaneous move.
    @(negedge clk);
    op = 2'd3; a = 32'd100; b = 32'd7; start = 1'b1; mthi = 1'b1; mtlo = 1'b1;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    #2;
    chk("start_wins_hold", {hi, lo}, {32'hCAFE_F00D, 32'hCAFE_F00D});
    wait_done(lat);
    chk("start_wins_res", {hi, lo}, {32'd2, 32'd14});

    // Randomized traffic against the model.
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      start = ($urandom % 3) == 0;
      op    = 2'($urandom);
      a     = pick();
      b     = pick();
      mthi  = ($urandom % 6) == 0;
      mtlo  = ($urandom % 6) == 0;
      rst   = ($urandom % 500) == 0;
    end
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0; rst = 1'b0;
    repeat (40) @(negedge clk);
    #3;
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
